instr_entry_ctrl: RTL
=====================

# instr_entry_ctrl

Front-end controller that receives the operator's button/switch instruction entry for the FPGA microprocessor and turns it into a clean, latched instruction for the datapath. It synchronises and debounces `btn[3:0]`, walks the seven-step entry sequence (idle, op, rd1, rd2, wr, execute, done), and latches `sw[3:0]` into the matching instruction field. It requests execution from the datapath and selects what the display path shows. It sits between the board pins and the register-file/ALU datapath inside `TOP`.

## Interface
- `DB_CYCLES`, 64: number of consecutive stable samples required before a button level is accepted (64 × 8 ns = 512 ns at 125 MHz).
- `DB_W`, 7: debounce counter width; must satisfy 2^DB_W > DB_CYCLES.

- `clk_ref`  in  1  125 MHz system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw`  in  4  raw switch levels; value for the current entry field.
- `btn`  in  4  raw buttons:
  - [0] advance
  - [1] show instruction (held)
  - [2] unused
  - [3] abort to idle
- `exec_ack`  in  1  datapath has completed the requested instruction (1-cycle pulse or held).
- `state`  out  3  current step, 0–6 = S0–S6.
- `op`, `rd1`, `rd2`, `wr`  out  4 each  latched instruction fields.
- `exec_req`  out  1  execution request to the datapath.
- `done`  out  1  high in S6.
- `disp_sel`  out  1  0 = result in binary on LED/SSD; 1 = instruction fields on SSD.

## Operation
- Button path for each bit: 2-flop synchroniser → debounce filter → rising-edge detector. The edge detector produces a one-cycle `pulse[i]` on each accepted press. `btn[1]` additionally yields a debounced level `hold1`.
- FSM:
  - S0 IDLE: advance → S1.
  - S1 OP: advance → latch `sw` into `op`, then S2.
  - S2 RD1: advance → latch `rd1`, then S3.
  - S3 RD2: advance → latch `rd2`, then S4.
  - S4 WR: advance → latch `wr`, then S5.
  - S5 EXEC:
    - `exec_req` = 1 while in S5 and `ack_seen` = 0.
    - On `exec_ack`, set `ack_seen` and drop `exec_req` on the next cycle.
    - Advance is ignored until `ack_seen` = 1; then advance → S6.
  - S6 DONE: `done` = 1; `disp_sel` = `hold1`. Advance is ignored.
- Abort (`pulse[3]`) → S0 from any state, including S5 with `exec_req` pending. Abort clears `ack_seen`, `exec_req` and `disp_sel`. Fields keep their values.
- Priority: `pulse[3]` over `pulse[0]`. `pulse[1]` and `hold1` affect only `disp_sel`, and only in S6.
- Fields are captured only on the advance out of their own state; `sw` changes at other times have no effect.
- Opcode values are not checked. Don't-care fields (e.g. `rd1` for WRITE) are captured as-is.

## Timing
- Reset values: `state` = 0, `op` = `rd1` = `rd2` = `wr` = 0, `exec_req` = 0, `done` = 0, `disp_sel` = 0, all sync/debounce state = 0.
- Debounce: the counter restarts on any mismatch between the synchronised sample and the accepted level. The new level is accepted when the count reaches DB_CYCLES.
- Latency: the state/field update lands on the edge DB_CYCLES+3 cycles after the first edge that samples the raw button high.
- Glitches shorter than DB_CYCLES cycles produce no pulse. Exactly one pulse is produced per accepted press, regardless of hold time.
- `exec_req` rises on the edge that enters S5. If `exec_ack` arrives in the first S5 cycle, `exec_req` is high for exactly 1 cycle.
- `rst_n` deassertion mid-sequence: everything returns to reset values immediately (asynchronous). The block restarts in S0.

## Configuration
- `INSTR_ENTRY_DEBOUNCE_EN` defined: full debounce filter, latency as above.
- Undefined: the debounce filter is bypassed. The edge detector sees the synchroniser output directly, giving a 3-cycle latency (for fast simulation). `DB_CYCLES` and `DB_W` are ignored.

## Structure
- Shared package `instr_pkg`:
  - state encoding `S_IDLE`..`S_DONE` (0–6)
  - opcode constants: WRITE = 1, READ = 2, AND = 5, ADD = 10, ADDI, SUB = 11, SLL = 14
  - button index constants `BTN_ADV` = 0, `BTN_SHOW` = 1, `BTN_RST` = 3
- Sub-module `btn_debounce`, one instance per button bit: synchroniser + filter + edge pulse. The macro switch is contained inside it.

## Test plan
- WRITE entry: reset; pulse btn[0] (1 µs). Then, with each advance pulse 5 µs long and `sw` set before the press:
  - S1, `sw` = 1
  - S2, don't care
  - S3, `sw` = 5
  - S4, `sw` = 1

  → `op` = 1, `rd2` = 5, `wr` = 1, `state` = 5, `exec_req` = 1. Apply `exec_ack` → `exec_req` = 0. Advance → `state` = 6, `done` = 1.
- Display: in S6, hold btn[1] for 10 µs → `disp_sel` = 1; release → 0. btn[1] pressed in S3 → `disp_sel` stays 0.
- ADD entry: `sw` = 10, 1, 2, 3 captured in S1–S4 → `op` = 10, `rd1` = 1, `rd2` = 2, `wr` = 3. Advance pressed in S5 before `exec_ack` → state stays 5.
- Abort: btn[3] in S3 → `state` = 0 after DB_CYCLES+3 cycles, fields unchanged. btn[3] + btn[0] pressed together in S1 → S0.
- Debounce: 40-cycle btn[0] glitch in S0 → no transition. A 200-cycle press → exactly one transition.
- Reset: drop `rst_n` in S5 with `exec_req` = 1 → all outputs 0 in the same cycle. After release → S0.

Source files
------------

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared state, opcode and button encodings for instruction entry
package instr_pkg;

  // Entry steps, S0..S6 as seen on the state output
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP   = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_WR   = 3'd4,
    S_EXEC = 3'd5,
    S_DONE = 3'd6
  } entry_state_t;

  // Opcodes understood by the datapath; the entry controller never checks them
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd10;
  localparam logic [3:0] OP_ADDI  = 4'd10;  // shares the ADD encoding
  localparam logic [3:0] OP_SUB   = 4'd11;
  localparam logic [3:0] OP_SLL   = 4'd14;

  // Button bit positions
  localparam int BTN_ADV  = 0;
  localparam int BTN_SHOW = 1;
  localparam int BTN_RST  = 3;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchroniser, debounce filter (INSTR_ENTRY_DEBOUNCE_EN) and press pulse
module btn_debounce #(
  parameter int DB_CYCLES = 64,
  parameter int DB_W      = 7
) (
  input  logic clk_ref,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse
);

  logic sync1, sync2;
  logic level_q, level_d;

  // two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef INSTR_ENTRY_DEBOUNCE_EN
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);
  logic [DB_W-1:0] cnt;

  // accept the new level once DB_CYCLES consecutive samples disagree with the old one
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      level_q <= 1'b0;
    end else if (sync2 == level_q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      level_q <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_db_cfg;
  assign unused_db_cfg = (DB_CYCLES > 0) ^ (DB_W > 0);
  assign level_q = sync2;
`endif

  // registered rising-edge detect: one pulse per accepted press
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_d <= level_q;
      pulse   <= level_q & ~level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/instr_entry_ctrl.sv
// rtl/instr_entry_ctrl.sv - button-driven instruction entry FSM; debounce via INSTR_ENTRY_DEBOUNCE_EN
import instr_pkg::*;

module instr_entry_ctrl #(
  parameter int DB_CYCLES = 64,
  parameter int DB_W      = 7
) (
  input  logic       clk_ref,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic [3:0] btn,
  input  logic       exec_ack,
  output logic [2:0] state,
  output logic [3:0] op,
  output logic [3:0] rd1,
  output logic [3:0] rd2,
  output logic [3:0] wr,
  output logic       exec_req,
  output logic       done,
  output logic       disp_sel
);

  logic [3:0] pulse;
  logic [3:0] level;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_db (
      .clk_ref(clk_ref),
      .rst_n  (rst_n),
      .raw    (btn[i]),
      .level  (level[i]),
      .pulse  (pulse[i])
    );
  end

  // the show press only matters as a held level, and btn[2] has no function
  logic unused_btn;
  assign unused_btn = ^{pulse[BTN_SHOW], pulse[2], level[3:2], level[BTN_ADV]};

  entry_state_t cur, nxt;
  logic         ack_seen, ack_seen_nxt;
  logic [3:0]   op_nxt, rd1_nxt, rd2_nxt, wr_nxt;
  logic         adv;

  assign adv = pulse[BTN_ADV];

  // state, ack flag and instruction field registers
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= S_IDLE;
      ack_seen <= 1'b0;
      op       <= '0;
      rd1      <= '0;
      rd2      <= '0;
      wr       <= '0;
    end else begin
      cur      <= nxt;
      ack_seen <= ack_seen_nxt;
      op       <= op_nxt;
      rd1      <= rd1_nxt;
      rd2      <= rd2_nxt;
      wr       <= wr_nxt;
    end
  end

  // next step, field capture on the advance out of each field's own step, and outputs
  always_comb begin
    nxt          = cur;
    ack_seen_nxt = ack_seen;
    op_nxt       = op;
    rd1_nxt      = rd1;
    rd2_nxt      = rd2;
    wr_nxt       = wr;
    state        = cur;
    exec_req     = (cur == S_EXEC) && !ack_seen;
    done         = (cur == S_DONE);
    disp_sel     = (cur == S_DONE) && level[BTN_SHOW];
    if (pulse[BTN_RST]) begin
      nxt          = S_IDLE;
      ack_seen_nxt = 1'b0;
    end else begin
      case (cur)
        S_IDLE: if (adv) nxt = S_OP;
        S_OP:   if (adv) begin op_nxt  = sw; nxt = S_RD1; end
        S_RD1:  if (adv) begin rd1_nxt = sw; nxt = S_RD2; end
        S_RD2:  if (adv) begin rd2_nxt = sw; nxt = S_WR;  end
        S_WR: begin
          if (adv) begin
            wr_nxt       = sw;
            nxt          = S_EXEC;
            ack_seen_nxt = 1'b0;
          end
        end
        S_EXEC: begin
          if (exec_ack) ack_seen_nxt = 1'b1;
          if (adv && ack_seen) begin
            nxt          = S_DONE;
            ack_seen_nxt = 1'b0;
          end
        end
        S_DONE: nxt = S_DONE;
        default: nxt = S_IDLE;
      endcase
    end
  end

endmodule
